systolic_output_collector: RTL and testbench
============================================

// Module: systolic_output_collector
// PURPOSE
// - Downstream of the 2x2 systolic array. Consumes the two south-edge column outputs (psum + valid).
// - Column 2 lags column 1 by one cycle; this block de-skews them into aligned 2-element rows.
// - Buffers rows in a FIFO and presents them on a ready/valid interface to the next stage
//   (unified buffer / activation writeback).
// PARAMETERS
// - DEPTH  8  row FIFO entries; power of two, >= 2
// PORTS
// - clk            in   1          single clock, rising edge
// - rst            in   1          synchronous, active-high reset
// - clear          in   1          synchronous soft clear, same effect as rst; rst has priority
// - col1_data_in   in   16         column-1 psum (array sys_data_out_21)
// - col1_valid_in  in   1          column-1 valid (array sys_valid_out_21)
// - col2_data_in   in   16         column-2 psum (array sys_data_out_22)
// - col2_valid_in  in   1          column-2 valid (array sys_valid_out_22)
// - out_valid      out  1          head row available
// - out_ready      in   1          consumer accepts head row
// - out_data_1     out  16         head row, column 1
// - out_data_2     out  16         head row, column 2
// - count          out  $clog2(DEPTH+1)  rows currently stored
// - overflow       out  1          sticky: a row was dropped because the FIFO was full
// - misalign       out  1          sticky: column valids failed to pair
// BEHAVIOUR
// - Reset/clear values: out_valid=0, out_data_1/2=0, count=0, overflow=0, misalign=0.
//   The FIFO is emptied and the skew register is invalidated.
// - Skew register: every cycle, pend_valid<=col1_valid_in and pend_data<=col1_data_in.
// - Row formation: a row {pend_data, col2_data_in} forms in any cycle where
//   col2_valid_in && pend_valid.
// - Mismatch: col2_valid_in && !pend_valid -> col2 sample dropped, misalign<=1.
//   pend_valid && !col2_valid_in -> pending col1 dropped, misalign<=1.
// - Push: a formed row is written at that clock edge.
//   - Full and out_ready=0: row dropped, overflow<=1, FIFO unchanged.
//   - Full and out_ready=1 (pop same edge): push accepted, count unchanged.
// - Pop: occurs on the edge where out_valid && out_ready.
//   - Empty FIFO with a simultaneous push: no pop; the row appears next cycle.
// - Output: show-ahead. out_valid = (count!=0). out_data_1/2 = head entry when valid, 0 when empty.
//   Data is stable while out_valid && !out_ready.
// - Latency: col1 sampled at edge k-1 and col2 at edge k -> out_valid=1 in the cycle after edge k.
//   Sustained throughput is 1 row/cycle.
// - Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
//   - count is tracked separately: +1 on push-only, -1 on pop-only, unchanged on both or neither.
// - Sticky flags clear only on rst/clear.
// - Reset mid-stream: any partially paired sample is discarded; no row is emitted from pre-reset data.
// - Data is 16-bit signed fixed point, passed through unmodified except as stated under CONFIGURATION.
// CONFIGURATION
// - OUTPUT_RELU_EN defined: ReLU is applied at push time to each element.
//   - Bit 15 set -> stored as 16'h0000; otherwise unchanged.
// - OUTPUT_RELU_EN undefined: elements are stored bit-exact.
// - Handshake and latency are identical in both builds.
// STRUCTURE
// - Shared package tpu_pkg:
//   - localparam DATA_W=16
//   - typedef logic [DATA_W-1:0] fixed_t
//   - typedef struct packed {fixed_t c1; fixed_t c2;} row_t
// - One sub-module, row_fifo: synchronous show-ahead FIFO of row_t, parameter DEPTH.
//   - Ports: push, pop, din, dout, count, full, empty.
// - The top level holds the skew register, pairing/mismatch logic, ReLU option and sticky flags.
// TESTING
// - Stream: col1 = 1,2,3 at cycles 0-2 and col2 = 10,20,30 at cycles 1-3, out_ready=1
//   -> rows (1,10), (2,20), (3,30) on consecutive cycles; first out_valid at cycle 2; misalign=0.
// - Backpressure: out_ready=0, push DEPTH+1 rows -> count=DEPTH and overflow=1; the first DEPTH
//   rows drain in order once out_ready=1.
// - Full with push and pop on the same edge -> count stays DEPTH, overflow=0, row order preserved.
// - Mismatch: col1_valid pulse with no col2 the next cycle -> misalign=1, no row; a following
//   correct pair is still emitted.
// - clear asserted mid-stream with 3 rows stored -> next cycle count=0, out_valid=0, flags=0.
// - ReLU build: col1=16'hFFF0, col2=16'h0005 -> row (0, 5). Non-ReLU build -> (16'hFFF0, 16'h0005).

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types for the systolic array datapath: element width, element type
// and the two-element row produced at the south edge of the array.
package tpu_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] fixed_t;

    typedef struct packed {
        fixed_t c1;
        fixed_t c2;
    } row_t;

endpackage

// File: rtl/systolic_output_collector_row_fifo.sv
// row_fifo: synchronous show-ahead FIFO of row_t. The head entry is always
// visible on dout; the caller guarantees no push when full without a pop and
// no pop when empty.
module row_fifo
    import tpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  row_t                       din,
    output row_t                       dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    row_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage write; contents are don't-care after reset because pointers restart
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer advance; power-of-two depth makes the natural overflow the wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy tracked independently of the pointers so full and empty are unambiguous
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CNT_FULL);
    assign empty = (r_count == '0);

endmodule

// File: rtl/systolic_output_collector.sv
// systolic_output_collector: de-skews the two south-edge column outputs of the
// 2x2 systolic array (column 2 lags column 1 by one cycle) into aligned rows,
// buffers them in a show-ahead row FIFO and offers them on a ready/valid port.
// Optional build macro OUTPUT_RELU_EN: clamp negative elements to zero at push.
module systolic_output_collector
    import tpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [DATA_W-1:0]          col1_data_in,
    input  logic                       col1_valid_in,
    input  logic [DATA_W-1:0]          col2_data_in,
    input  logic                       col2_valid_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data_1,
    output logic [DATA_W-1:0]          out_data_2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       misalign
);

    function automatic fixed_t apply_relu(input fixed_t x);
`ifdef OUTPUT_RELU_EN
        apply_relu = x[DATA_W-1] ? '0 : x;
`else
        apply_relu = x;
`endif
    endfunction

    logic   w_flush;
    logic   r_pend_vld_p0;
    fixed_t r_pend_data_p0;
    logic   w_form;
    logic   w_mis;
    logic   w_push;
    logic   w_pop;
    logic   w_drop;
    logic   w_full;
    logic   w_empty;
    row_t   w_row;
    row_t   w_head;
    logic   r_overflow;
    logic   r_misalign;

    assign w_flush = rst | clear;

    // Stage p0 control: column-1 valid held one cycle to meet the lagging column 2
    always_ff @(posedge clk) begin
        if (w_flush) r_pend_vld_p0 <= 1'b0;
        else         r_pend_vld_p0 <= col1_valid_in;
    end

    // Stage p0 data: column-1 sample, qualified only by r_pend_vld_p0
    always_ff @(posedge clk) begin
        r_pend_data_p0 <= col1_data_in;
    end

    // Pairing: both halves present forms a row; exactly one present is a misalignment.
    // A pop frees a slot on the same edge, so a full FIFO still accepts when out_ready.
    assign w_form  = col2_valid_in & r_pend_vld_p0;
    assign w_mis   = col2_valid_in ^ r_pend_vld_p0;
    assign w_pop   = ~w_empty & out_ready;
    assign w_push  = w_form & (~w_full | out_ready);
    assign w_drop  = w_form & w_full & ~out_ready;
    assign w_row   = {apply_relu(r_pend_data_p0), apply_relu(col2_data_in)};

    // Sticky error flags, cleared only by rst or clear
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_overflow <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (w_mis)  r_misalign <= 1'b1;
        end
    end

    row_fifo #(
        .DEPTH (DEPTH)
    ) u_row_fifo (
        .clk   (clk),
        .rst   (w_flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_row),
        .dout  (w_head),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Head row is masked to zero when nothing is stored
    assign out_valid  = ~w_empty;
    assign out_data_1 = w_empty ? '0 : w_head.c1;
    assign out_data_2 = w_empty ? '0 : w_head.c2;
    assign overflow   = r_overflow;
    assign misalign   = r_misalign;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Testbench for systolic_output_collector: table-driven directed vectors,
// hand-written corner-case sequences and randomized traffic, all checked
// against a queue-based reference model of the collector.
module tb_systolic_output_collector;
    import tpu_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             clk;
    logic             rst;
    logic             clear;
    logic [15:0]      col1_data_in;
    logic             col1_valid_in;
    logic [15:0]      col2_data_in;
    logic             col2_valid_in;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data_1;
    logic [15:0]      out_data_2;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             misalign;

    systolic_output_collector #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .col1_data_in  (col1_data_in),
        .col1_valid_in (col1_valid_in),
        .col2_data_in  (col2_data_in),
        .col2_valid_in (col2_valid_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data_1    (out_data_1),
        .out_data_2    (out_data_2),
        .count         (count),
        .overflow      (overflow),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: stored rows, last cycle's column-1 sample, sticky flags
    row_t   m_q[$];
    logic   m_pv  = 1'b0;
    fixed_t m_pd  = '0;
    logic   m_ovf = 1'b0;
    logic   m_mis = 1'b0;

    function automatic fixed_t m_relu(input fixed_t x);
`ifdef OUTPUT_RELU_EN
        return ($signed(x) < 0) ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic clr, input logic c1v, input fixed_t c1d,
                              input logic c2v, input fixed_t c2d, input logic rdy);
        logic popped;
        popped = (m_q.size() != 0) && rdy;
        if (r || clr) begin
            m_q.delete();
            m_pv  = 1'b0;
            m_ovf = 1'b0;
            m_mis = 1'b0;
        end else begin
            if (c2v != m_pv) m_mis = 1'b1;
            if (popped) void'(m_q.pop_front());
            if (c2v && m_pv) begin
                if (m_q.size() < DEPTH) m_q.push_back('{c1: m_relu(m_pd), c2: m_relu(c2d)});
                else                    m_ovf = 1'b1;
            end
            m_pv = c1v;
            m_pd = c1d;
        end
    endtask

    task automatic check_model();
        chk("model_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
        chk("model_d1", {16'd0, out_data_1}, (m_q.size() != 0) ? {16'd0, m_q[0].c1} : 32'd0);
        chk("model_d2", {16'd0, out_data_2}, (m_q.size() != 0) ? {16'd0, m_q[0].c2} : 32'd0);
        chk("model_count", 32'(count), 32'(m_q.size()));
        chk("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("model_misalign", {31'd0, misalign}, {31'd0, m_mis});
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare on the falling edge
    task automatic cyc(input logic r, input logic clr, input logic c1v, input logic [15:0] c1d,
                       input logic c2v, input logic [15:0] c2d, input logic rdy);
        rst           = r;
        clear         = clr;
        col1_valid_in = c1v;
        col1_data_in  = c1d;
        col2_valid_in = c2v;
        col2_data_in  = c2d;
        out_ready     = rdy;
        @(posedge clk);
        model_edge(r, clr, c1v, c1d, c2v, c2d, rdy);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic        c1v;
        logic [15:0] c1d;
        logic        c2v;
        logic [15:0] c2d;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_d1;
        logic [15:0] e_d2;
        int          e_count;
        logic        e_mis;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Directed stream: col1 = 1,2,3 then col2 = 10,20,30 one cycle later
        tbl[0] = '{1'b1, 16'd1, 1'b0, 16'd0,  1'b1, 1'b0, 16'd0, 16'd0,  0, 1'b0};
        tbl[1] = '{1'b1, 16'd2, 1'b1, 16'd10, 1'b1, 1'b1, 16'd1, 16'd10, 1, 1'b0};
        tbl[2] = '{1'b1, 16'd3, 1'b1, 16'd20, 1'b1, 1'b1, 16'd2, 16'd20, 1, 1'b0};
        tbl[3] = '{1'b0, 16'd0, 1'b1, 16'd30, 1'b1, 1'b1, 16'd3, 16'd30, 1, 1'b0};
        tbl[4] = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd0, 16'd0,  0, 1'b0};
        // Negative column-1 element, held with out_ready low, then drained
        tbl[5] = '{1'b1, 16'hFFF0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 0, 1'b0};
`ifdef OUTPUT_RELU_EN
        tbl[6] = '{1'b0, 16'd0, 1'b1, 16'h0005, 1'b0, 1'b1, 16'h0000, 16'h0005, 1, 1'b0};
`else
        tbl[6] = '{1'b0, 16'd0, 1'b1, 16'h0005, 1'b0, 1'b1, 16'hFFF0, 16'h0005, 1, 1'b0};
`endif
        tbl[7] = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd0, 16'd0,  0, 1'b0};

        // Reset state
        cyc(1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 16'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 16'h5678, 1'b1);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_d1", {16'd0, out_data_1}, 32'd0);
        chk("reset_flags", {30'd0, overflow, misalign}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, tbl[i].c1v, tbl[i].c1d, tbl[i].c2v, tbl[i].c2d, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_d1", i), {16'd0, out_data_1}, {16'd0, tbl[i].e_d1});
            chk($sformatf("tbl%0d_d2", i), {16'd0, out_data_2}, {16'd0, tbl[i].e_d2});
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_mis", i), {31'd0, misalign}, {31'd0, tbl[i].e_mis});
        end

        // Backpressure: DEPTH+1 rows with out_ready low, last one dropped
        for (int j = 0; j <= DEPTH + 1; j++) begin
            cyc(1'b0, 1'b0, j <= DEPTH, 16'(j + 1), j > 0, 16'(j * 10), 1'b0);
        end
        chk("bp_count", 32'(count), DEPTH);
        chk("bp_overflow", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("bp_order_d1", {16'd0, out_data_1}, 32'(i + 1));
            chk("bp_order_d2", {16'd0, out_data_2}, 32'((i + 1) * 10));
            cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
        end
        chk("bp_drained", 32'(count), 32'd0);

        // Full with push and pop on the same edge
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
        chk("clr_overflow", {31'd0, overflow}, 32'd0);
        for (int j = 0; j <= DEPTH + 4; j++) begin
            cyc(1'b0, 1'b0, j < DEPTH + 4, 16'(200 + j), j > 0, 16'(300 + j), j > DEPTH);
            if (j >= DEPTH) begin
                chk("fullpp_count", 32'(count), DEPTH);
                chk("fullpp_overflow", {31'd0, overflow}, 32'd0);
            end
        end
        for (int i = 0; i <= DEPTH; i++) cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);

        // Mismatch: column-1 pulse with no column 2, then a good pair
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'd9, 1'b0, 16'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_norow", 32'(count), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 16'd7, 1'b0, 16'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 16'd70, 1'b0);
        chk("mis_pair_d1", {16'd0, out_data_1}, 32'd7);
        chk("mis_pair_d2", {16'd0, out_data_2}, 32'd70);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
        // Column 2 with nothing pending
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 16'd55, 1'b1);
        chk("mis_c2only", {31'd0, misalign}, 32'd1);
        chk("mis_c2only_cnt", 32'(count), 32'd0);

        // Clear mid-stream with 3 rows stored and a column-1 sample pending
        cyc(1'b0, 1'b0, 1'b1, 16'd11, 1'b0, 16'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'd12, 1'b1, 16'd21, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'd13, 1'b1, 16'd22, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'd14, 1'b1, 16'd23, 1'b0);
        chk("clr_pre_count", 32'(count), 32'd3);
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 16'd24, 1'b0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_flags", {30'd0, overflow, misalign}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);

        // Randomized traffic with occasional reset/clear and varying backpressure
        begin
            logic prev_c1v;
            prev_c1v = 1'b0;
            for (int k = 0; k < 600; k++) begin
                logic r, cl, c1v, c2v, rdy;
                r   = ($urandom_range(0, 149) == 0);
                cl  = ($urandom_range(0, 59) == 0);
                c1v = ($urandom_range(0, 3) != 0);
                c2v = ($urandom_range(0, 19) == 0) ? ~prev_c1v : prev_c1v;
                if ((k / 100) % 2 == 0) rdy = ($urandom_range(0, 3) != 0);
                else                    rdy = ($urandom_range(0, 3) == 0);
                cyc(r, cl, c1v, 16'($urandom), c2v, 16'($urandom), rdy);
                prev_c1v = c1v;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
